// File: rtl/fetch_unit_r32i_if.sv
// Instruction-memory req/ack port between the fetch unit (master) and instruction memory (slave).
interface fetch_unit_r32i_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] ImemAddr;
  logic              ImemReq;
  logic              ImemAck;
  logic [DATA_W-1:0] ImemData;

  modport master (
    output ImemAddr,
    output ImemReq,
    input  ImemAck,
    input  ImemData
  );

  modport slave (
    input  ImemAddr,
    input  ImemReq,
    output ImemAck,
    output ImemData
  );
endinterface

// File: rtl/fetch_unit_r32i.sv
// RV32I instruction fetch stage: owns the PC, fetches one word per instruction over a req/ack
// port and selects the next PC from decoder branch controls; halts on a misaligned next PC.
module fetch_unit_r32i #(
  parameter int unsigned dataW    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             nReset,
  fetch_unit_r32i_if.master imem,
  output logic [dataW-1:0] rawIns,
  output logic             InsValid,
  output logic [dataW-1:0] ProgAddr,
  output logic [dataW-1:0] LinkAddr,
  input  logic             ExecDone,
  input  logic             AlwaysBranch,
  input  logic             TestBranch,
  input  logic             AbsoluteBranch,
  input  logic             BranchCond,
  input  logic [dataW-1:0] BranchAddr,
  output logic             FetchFault
);

  localparam logic [dataW-1:0] NOP_INSN   = dataW'(32'h0000_0013);
  localparam logic [dataW-1:0] INSN_BYTES = dataW'(4);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e            state_q;
  logic [dataW-1:0]  pc_q;
  logic [dataW-1:0]  raw_ins_q;
  logic              ins_valid_q;
  logic              imem_req_q;
  logic              fault_q;

  logic              take_c;
  logic [dataW-1:0]  pc_d;
  logic              pc_misaligned_c;

  // Next-PC selection; JALR-style absolute targets have bit0 cleared before the alignment check.
  always_comb begin
    take_c = AlwaysBranch | (TestBranch & BranchCond);
    pc_d   = pc_q + INSN_BYTES;
    if (take_c) begin
      if (AbsoluteBranch) begin
        pc_d = {BranchAddr[dataW-1:1], 1'b0};
      end else begin
        pc_d = pc_q + BranchAddr;
      end
    end
    pc_misaligned_c = (pc_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      raw_ins_q   <= NOP_INSN;
      ins_valid_q <= 1'b0;
      imem_req_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          imem_req_q <= 1'b1;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (imem.ImemAck) begin
            raw_ins_q   <= imem.ImemData;
            ins_valid_q <= 1'b1;
            imem_req_q  <= 1'b0;
            state_q     <= VALID;
          end
        end
        VALID: begin
          if (ExecDone) begin
            ins_valid_q <= 1'b0;
            if (pc_misaligned_c) begin
              fault_q <= 1'b1;
              state_q <= FAULT;
            end else begin
              pc_q    <= pc_d;
              state_q <= FETCH;
            end
          end
        end
        FAULT: begin
          imem_req_q  <= 1'b0;
          ins_valid_q <= 1'b0;
          fault_q     <= 1'b1;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

  // The address is the PC register itself, so it cannot move while a request is outstanding.
  assign imem.ImemAddr = pc_q;
  assign imem.ImemReq  = imem_req_q;
  assign rawIns        = raw_ins_q;
  assign InsValid      = ins_valid_q;
  assign ProgAddr      = pc_q;
  assign LinkAddr      = pc_q + INSN_BYTES;
  assign FetchFault    = fault_q;

endmodule

// File: tb/tb_fetch_unit_r32i.sv
// Randomized self-checking bench for fetch_unit_r32i with a PC-level reference model.
module tb_fetch_unit_r32i;

  logic        clk = 1'b0;
  logic        nReset;
  logic [31:0] rawIns, ProgAddr, LinkAddr, BranchAddr;
  logic        InsValid, FetchFault;
  logic        ExecDone, AlwaysBranch, TestBranch, AbsoluteBranch, BranchCond;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] ref_pc;

  always #5 clk = ~clk;

  fetch_unit_r32i_if #(.DATA_W(32)) imem ();

  fetch_unit_r32i #(.dataW(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .nReset        (nReset),
    .imem          (imem.master),
    .rawIns        (rawIns),
    .InsValid      (InsValid),
    .ProgAddr      (ProgAddr),
    .LinkAddr      (LinkAddr),
    .ExecDone      (ExecDone),
    .AlwaysBranch  (AlwaysBranch),
    .TestBranch    (TestBranch),
    .AbsoluteBranch(AbsoluteBranch),
    .BranchCond    (BranchCond),
    .BranchAddr    (BranchAddr),
    .FetchFault    (FetchFault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Architectural next-PC rule.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic ab, input logic tb,
                                           input logic abs_b, input logic cond, input logic [31:0] ba);
    if (ab || (tb && cond)) return abs_b ? (ba & 32'hFFFF_FFFE) : pc + ba;
    return pc + 32'd4;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    ExecDone = 1'b0; AlwaysBranch = 1'b0; TestBranch = 1'b0;
    AbsoluteBranch = 1'b0; BranchCond = 1'b0; BranchAddr = 32'h0;
    imem.ImemAck = 1'b0; imem.ImemData = 32'h0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"},   32'(imem.ImemReq), 32'd0);
    chk({tag, "_valid"}, 32'(InsValid),     32'd0);
    chk({tag, "_raw"},   rawIns,            32'h0000_0013);
    chk({tag, "_fault"}, 32'(FetchFault),   32'd0);
    chk({tag, "_pc"},    ProgAddr,          32'h0000_0000);
  endtask

  task automatic apply_reset;
    nReset = 1'b0;
    clear_inputs();
    #1;
    check_reset_values("rst");
    tick();
    tick();
    nReset = 1'b1;
    ref_pc = 32'h0;
  endtask

  // Waits for the request, withholds ack for ack_delay cycles with noise, then returns the word.
  task automatic fetch_one(input int ack_delay, input int exp_lat);
    int          n = 0;
    logic [31:0] raw_before;
    while (imem.ImemReq !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("fetch_lat", 32'(n), 32'(exp_lat));
    chk("req_addr", imem.ImemAddr, ref_pc);
    chk("wait_valid", 32'(InsValid), 32'd0);
    raw_before = rawIns;
    for (int i = 0; i < ack_delay; i++) begin
      ExecDone      = 1'($urandom_range(0, 1));
      imem.ImemData = $urandom;
      tick();
      chk("hold_req",   32'(imem.ImemReq), 32'd1);
      chk("hold_addr",  imem.ImemAddr,     ref_pc);
      chk("hold_valid", 32'(InsValid),     32'd0);
      chk("hold_raw",   rawIns,            raw_before);
    end
    ExecDone      = 1'b0;
    imem.ImemAck  = 1'b1;
    imem.ImemData = mem_word(ref_pc);
    tick();
    imem.ImemAck  = 1'b0;
    imem.ImemData = $urandom;
    chk("ins_valid", 32'(InsValid),     32'd1);
    chk("raw_ins",   rawIns,            mem_word(ref_pc));
    chk("prog_addr", ProgAddr,          ref_pc);
    chk("link_addr", LinkAddr,          ref_pc + 32'd4);
    chk("req_drop",  32'(imem.ImemReq), 32'd0);
    chk("no_fault",  32'(FetchFault),   32'd0);
  endtask

  // Holds in VALID with ack noise, then retires the instruction with the given branch controls.
  task automatic exec_one(input logic ab, input logic tbr, input logic abs_b, input logic cond,
                          input logic [31:0] ba, input int hold, output logic faulted);
    logic [31:0] nxt;
    for (int i = 0; i < hold; i++) begin
      imem.ImemAck   = 1'($urandom_range(0, 1));
      imem.ImemData  = $urandom;
      AlwaysBranch   = 1'($urandom);
      TestBranch     = 1'($urandom);
      AbsoluteBranch = 1'($urandom);
      BranchCond     = 1'($urandom);
      BranchAddr     = $urandom;
      tick();
      chk("valid_hold", 32'(InsValid),     32'd1);
      chk("valid_raw",  rawIns,            mem_word(ref_pc));
      chk("valid_req",  32'(imem.ImemReq), 32'd0);
      chk("valid_pc",   ProgAddr,          ref_pc);
    end
    imem.ImemAck = 1'b0;
    AlwaysBranch = ab; TestBranch = tbr; AbsoluteBranch = abs_b; BranchCond = cond; BranchAddr = ba;
    ExecDone = 1'b1;
    tick();
    clear_inputs();
    nxt     = ref_next(ref_pc, ab, tbr, abs_b, cond, ba);
    faulted = (nxt[1:0] != 2'b00);
    if (faulted) begin
      chk("fault_set",   32'(FetchFault),   32'd1);
      chk("fault_req",   32'(imem.ImemReq), 32'd0);
      chk("fault_valid", 32'(InsValid),     32'd0);
      for (int i = 0; i < 3; i++) begin
        ExecDone     = 1'($urandom);
        imem.ImemAck = 1'($urandom);
        tick();
      end
      clear_inputs();
      chk("fault_stuck", 32'(FetchFault),   32'd1);
      chk("fault_noreq", 32'(imem.ImemReq), 32'd0);
    end else begin
      chk("retire_valid", 32'(InsValid),   32'd0);
      chk("retire_fault", 32'(FetchFault), 32'd0);
      ref_pc = nxt;
    end
  endtask

  task automatic jump_to(input logic [31:0] target);
    logic f;
    exec_one(1'b1, 1'b0, 1'b1, 1'b0, target, 1, f);
    fetch_one(0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        f;
    logic        ab, tbr, abs_b, cond;
    logic [31:0] ba;
    @(negedge clk);
    apply_reset();

    // Sequential fetch from reset.
    for (int i = 0; i < 4; i++) begin
      fetch_one(0, 1);
      chk("seq_addr", imem.ImemAddr, 32'(4 * i));
      if (i < 3) exec_one(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, i, f);
    end

    // Conditional relative branch, taken and not taken.
    jump_to(32'h0000_0100);
    exec_one(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 0, f);
    fetch_one(0, 1);
    chk("br_taken", imem.ImemAddr, 32'h0000_00F8);
    jump_to(32'h0000_0100);
    exec_one(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 0, f);
    fetch_one(0, 1);
    chk("br_not_taken", imem.ImemAddr, 32'h0000_0104);

    // Absolute jump with bit0 cleared.
    jump_to(32'h0000_0040);
    exec_one(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2001, 0, f);
    fetch_one(0, 1);
    chk("jalr_bit0", imem.ImemAddr, 32'h0000_2000);

    // PC wrap with a long ack stall.
    exec_one(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 0, f);
    fetch_one(10, 1);
    exec_one(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, f);
    fetch_one(0, 1);
    chk("pc_wrap", imem.ImemAddr, 32'h0000_0000);

    // Misaligned absolute target halts the core.
    jump_to(32'h0000_0040);
    exec_one(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_2002, 0, f);
    chk("fault_flag", 32'(FetchFault), 32'd1);
    apply_reset();

    // Reset in WAIT, then a late ack after release.
    tick();
    chk("w_req", 32'(imem.ImemReq), 32'd1);
    tick();
    nReset = 1'b0;
    #1;
    check_reset_values("midwait");
    tick();
    nReset        = 1'b1;
    imem.ImemAck  = 1'b1;
    imem.ImemData = 32'hDEAD_BEEF;
    tick();
    imem.ImemAck = 1'b0;
    chk("late_ack_valid", 32'(InsValid),     32'd0);
    chk("late_ack_raw",   rawIns,            32'h0000_0013);
    chk("late_ack_req",   32'(imem.ImemReq), 32'd1);
    chk("late_ack_addr",  imem.ImemAddr,     32'h0000_0000);
    ref_pc = 32'h0;
    fetch_one(2, 0);
    exec_one(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, f);

    // Random instruction stream.
    for (int k = 0; k < 150; k++) begin
      fetch_one(int'($urandom_range(0, 3)), 1);
      ab    = ($urandom_range(0, 3) == 0);
      tbr   = 1'($urandom);
      abs_b = 1'($urandom);
      cond  = 1'($urandom);
      if (abs_b) ba = $urandom & 32'h0000_FFFD;
      else       ba = 32'(($urandom_range(0, 255) - 128) * 4);
      if ($urandom_range(0, 15) == 0) ba = ba | 32'h2;
      exec_one(ab, tbr, abs_b, cond, ba, int'($urandom_range(0, 2)), f);
      if (f) apply_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
